// File: rtl/lift_ctrl.sv
// ---------------------------------------------------------------------------
// lift_ctrl -- single-car lift controller with SCAN scheduling.
//
// Latches floor calls into a pending mask, moves the car one floor every
// TRAVEL_TICKS cycles, holds the doors open for DOOR_TICKS cycles at each
// served floor, and waits for the door sensor before going idle again.
// The car keeps its direction while requests remain beyond it, then reverses.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-high reset
//   call_req        one request bit per floor
//   doors_closed    door sensor: doors confirmed shut
//   state           0 IDLE, 1 MOVE_UP, 2 MOVE_DOWN, 3 DOOR_OPEN, 4 DOOR_CLOSE
//   cur_floor       current floor index
//   pending         latched, still-unserved requests
//   motor_on        high in MOVE_UP / MOVE_DOWN
//   motor_direction 1 = up, 0 = down; holds its value when not moving
//   door_open       high in DOOR_OPEN
//   fan_on          high whenever the state is not IDLE
// ---------------------------------------------------------------------------
module lift_ctrl #(
    parameter int NUM_FLOORS   = 8,
    parameter int FLOOR_W      = 3,
    parameter int DOOR_TICKS   = 4,
    parameter int TRAVEL_TICKS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  doors_closed,
    output logic [2:0]            state,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  motor_on,
    output logic                  motor_direction,
    output logic                  door_open,
    output logic                  fan_on
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_MOVE_UP    = 3'd1,
        S_MOVE_DOWN  = 3'd2,
        S_DOOR_OPEN  = 3'd3,
        S_DOOR_CLOSE = 3'd4
    } state_t;

    localparam int TCNT_W = $clog2(TRAVEL_TICKS + 1);
    localparam int DCNT_W = $clog2(DOOR_TICKS + 1);
    localparam logic [TCNT_W-1:0] TRAVEL_LAST = TCNT_W'(TRAVEL_TICKS - 1);
    localparam logic [DCNT_W-1:0] DOOR_LAST   = DCNT_W'(DOOR_TICKS - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);

    state_t                  state_q, state_d;
    logic [FLOOR_W-1:0]      floor_q, floor_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic                    dir_q, dir_d;
    logic [TCNT_W-1:0]       tcnt_q, tcnt_d;
    logic [DCNT_W-1:0]       dcnt_q, dcnt_d;

    // Any request strictly above / strictly below floor fl.
    function automatic logic any_above(input logic [NUM_FLOORS-1:0] req,
                                       input logic [FLOOR_W-1:0]    fl);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(fl)) r = r | req[i];
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] req,
                                       input logic [FLOOR_W-1:0]    fl);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(fl)) r = r | req[i];
        end
        return r;
    endfunction

    logic                 going_up;
    logic                 at_limit;
    logic [FLOOR_W-1:0]   next_floor;
    logic                 beyond_next;
    logic                 req_above;
    logic                 req_below;
    logic                 here_call;

    always_comb begin
        going_up    = (state_q == S_MOVE_UP);
        at_limit    = going_up ? (floor_q == TOP_FLOOR) : (floor_q == '0);
        next_floor  = going_up ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
        beyond_next = going_up ? any_above(pending_q, next_floor)
                               : any_below(pending_q, next_floor);
        req_above   = any_above(pending_q, floor_q);
        req_below   = any_below(pending_q, floor_q);
        here_call   = call_req[floor_q];
    end

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_d     = dir_q;
        tcnt_d    = tcnt_q;
        dcnt_d    = dcnt_q;
        pending_d = pending_q | call_req;

        case (state_q)
            S_IDLE: begin
                tcnt_d = '0;
                if (pending_q[floor_q]) begin
                    state_d = S_DOOR_OPEN;
                    dcnt_d  = '0;
                end else if (req_above && (dir_q || !req_below)) begin
                    state_d = S_MOVE_UP;
                    dir_d   = 1'b1;
                end else if (req_below) begin
                    state_d = S_MOVE_DOWN;
                    dir_d   = 1'b0;
                end
            end

            S_MOVE_UP, S_MOVE_DOWN: begin
                if (at_limit) begin
                    // Defensive: never step past the end floors.
                    state_d = S_IDLE;
                    tcnt_d  = '0;
                end else if (tcnt_q == TRAVEL_LAST) begin
                    tcnt_d  = '0;
                    floor_d = next_floor;
                    if (pending_q[next_floor]) begin
                        state_d = S_DOOR_OPEN;
                        dcnt_d  = '0;
                    end else if (!beyond_next) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end

            S_DOOR_OPEN: begin
                // A call at this floor while open just extends the opening.
                if (here_call) begin
                    dcnt_d = '0;
                end else if (dcnt_q == DOOR_LAST) begin
                    state_d = S_DOOR_CLOSE;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end

            S_DOOR_CLOSE: begin
                // Reopen wins over the sensor so nobody is shut out.
                if (here_call) begin
                    state_d = S_DOOR_OPEN;
                    dcnt_d  = '0;
                end else if (doors_closed) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The floor being served (or still open) is never left pending.
        if (state_d == S_DOOR_OPEN) pending_d[floor_d] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            floor_q   <= '0;
            pending_q <= '0;
            dir_q     <= 1'b1;
            tcnt_q    <= '0;
            dcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            dir_q     <= dir_d;
            tcnt_q    <= tcnt_d;
            dcnt_q    <= dcnt_d;
        end
    end

    assign state           = state_q;
    assign cur_floor       = floor_q;
    assign pending         = pending_q;
    assign motor_on        = (state_q == S_MOVE_UP) || (state_q == S_MOVE_DOWN);
    assign motor_direction = dir_q;
    assign door_open       = (state_q == S_DOOR_OPEN);
    assign fan_on          = (state_q != S_IDLE);

endmodule

// File: doc/lift_ctrl.md
LIFT_CTRL -- requirements
Module: lift_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_FLOORS, default 8, giving the number of served floors (range 2..16).
REQ-002 The block SHALL have parameter FLOOR_W, default 3, giving the floor index width (clog2 of NUM_FLOORS).
REQ-003 The block SHALL have parameter DOOR_TICKS, default 4, giving the number of cycles door_open is held per opening (at least 1).
REQ-004 The block SHALL have parameter TRAVEL_TICKS, default 3, giving the number of cycles per one-floor move (at least 1).
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port call_req, input, NUM_FLOORS bits: one bit per floor; a 1 requests a stop at that floor.
REQ-008 Port doors_closed, input, 1 bit: door-sensor confirmation that the doors are shut.
REQ-009 Port state, output, 3 bits: IDLE=0, MOVE_UP=1, MOVE_DOWN=2, DOOR_OPEN=3, DOOR_CLOSE=4.
REQ-010 Port cur_floor, output, FLOOR_W bits: current floor index.
REQ-011 Port pending, output, NUM_FLOORS bits: latched, still-unserved requests.
REQ-012 Port motor_on, output, 1 bit: 1 exactly in MOVE_UP or MOVE_DOWN.
REQ-013 Port motor_direction, output, 1 bit: 1=up, 0=down; holds its last value outside the move states.
REQ-014 Port door_open, output, 1 bit: 1 exactly in DOOR_OPEN.
REQ-015 Port fan_on, output, 1 bit: 1 whenever state is not IDLE.

Function
REQ-016 Latching: on each edge, pending SHALL become pending OR call_req; a request first appears in pending one cycle after call_req is sampled.
REQ-017 Clearing: pending[cur_floor] SHALL be cleared on the edge that enters DOOR_OPEN; a call_req for cur_floor sampled while in DOOR_OPEN SHALL NOT be latched.
REQ-018 IDLE priority 1: if pending[cur_floor] is set, next state SHALL be DOOR_OPEN.
REQ-019 IDLE priority 2: otherwise, if there is a request above and (motor_direction=1 or no request below), next state SHALL be MOVE_UP.
REQ-020 IDLE priority 3: otherwise, if there is a request below, next state SHALL be MOVE_DOWN; otherwise the state SHALL stay IDLE.
REQ-021 Travel timing: in MOVE_UP/MOVE_DOWN, a travel counter SHALL count TRAVEL_TICKS cycles.
REQ-022 Travel step: on the TRAVEL_TICKS-th cycle, cur_floor SHALL step by +1 or -1, and the next state SHALL be DOOR_OPEN if the new floor is pending, else stay in the same move state if requests remain beyond it in that direction, else IDLE.
REQ-023 Floor bounds: cur_floor SHALL never exceed NUM_FLOORS-1 or go below 0; MOVE_UP SHALL never be entered from the top floor, nor MOVE_DOWN from floor 0.
REQ-024 Door timing: DOOR_OPEN SHALL last exactly DOOR_TICKS cycles; a call_req for cur_floor sampled during DOOR_OPEN SHALL reload the door counter.
REQ-025 Door close: after DOOR_OPEN the state SHALL go to DOOR_CLOSE, then to IDLE on the first edge with doors_closed=1.
REQ-026 Reopen: a call_req for cur_floor sampled in DOOR_CLOSE SHALL return the state to DOOR_OPEN with a full DOOR_TICKS count, taking priority over doors_closed.
REQ-027 Direction scheduling: the block SHALL serve requests in SCAN order, continuing the current direction while requests exist beyond cur_floor, then reversing.
REQ-028 Unused encodings: state codes 5-7 SHALL recover to IDLE on the next edge.

Reset
REQ-029 While reset=1, independent of clk: state=0, cur_floor=0, pending=0, motor_on=0, motor_direction=1, door_open=0, fan_on=0, all counters=0.
REQ-030 Reset asserted mid-move or mid-door SHALL abandon the operation and discard every pending request.

Verification
REQ-031 Reset check: assert reset -> all outputs take the REQ-029 values with no clock edge needed.
REQ-032 Same-floor call: at floor 0 IDLE, pulse call_req=8'h01 -> door_open=1 for 4 cycles, state=4, then doors_closed=1 -> state=0 and pending=0.
REQ-033 Multi-floor move: from floor 0, pulse call_req[3] -> motor_on=1 for 9 cycles, cur_floor steps 1,2,3 every 3 cycles, then state=3 at floor 3.
REQ-034 SCAN order: moving up from 3 toward 6, pulse call_req[1] and call_req[5] -> stops at 5, then 6, then reverses (motor_direction=0) to 1.
REQ-035 Reopen: in DOOR_CLOSE with doors_closed=0, pulse call_req[cur_floor] -> state=3 and door_open held another 4 cycles.
REQ-036 Async reset: assert reset in MOVE_UP between clock edges -> state=0, cur_floor=0, pending=0 immediately.
